// File: rtl/freq_pkg.sv
// Shared definitions for the frequency synthesiser and its gate timer.
//   state_t             : controller states (IDLE waits for a config, RUN generates)
//   DEFAULT_GATE_CYCLES : default gate phase length in clock cycles; the
//                         frequency counter uses the same value, so both
//                         ends agree on the gate length
package freq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_GATE_CYCLES = 1000;

endpackage

// File: rtl/gate_timer.sv
// Gate timer: produces the measurement gate, which starts high and toggles
// every GATE_CYCLES clock cycles for as long as it is enabled.
//   i_clk    : system clock, rising edge
//   i_rst    : synchronous active-high reset
//   i_clear  : force the gate low and the counter to zero (run ended)
//   i_start  : begin a new gate sequence (gate high, counter reloaded)
//   i_enable : advance the counter (high while the synthesiser runs)
//   o_gate   : registered gate output
module gate_timer
  import freq_pkg::*;
#(
  parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_start,
  input  logic i_enable,
  output logic o_gate
);

  localparam int CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(GATE_CYCLES - 1);

  logic [CNT_W-1:0] r_count;
  logic             r_gate;

  // The counter holds the number of cycles left in the current gate phase
  // after this one; reaching zero flips the gate and starts the next phase.
  // Clear has priority over start so an abort always leaves the gate low.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
      r_gate  <= 1'b0;
    end else if (i_start) begin
      r_count <= RELOAD;
      r_gate  <= 1'b1;
    end else if (i_enable) begin
      if (r_count == '0) begin
        r_count <= RELOAD;
        r_gate  <= ~r_gate;
      end else begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_gate = r_gate;

endmodule

// File: rtl/freq_synth.sv
// Programmable square-wave generator with matching measurement gate.
// A configuration (half-period, burst length) is accepted over a valid/ready
// handshake while idle; the block then produces a square wave on sigout
// either for a fixed number of full periods or until stopped.
//   clck      : system clock, rising edge
//   rst       : synchronous active-high reset
//   cfg_valid : configuration offered
//   cfg_ready : configuration can be accepted (high only while idle)
//   cfg_half  : half-period in clock cycles (0 behaves as 1)
//   cfg_count : burst length in full periods (0 = run until stopped)
//   stop      : abort the current run
//   sigout    : generated square wave
//   gate      : measurement gate, toggles every GATE_CYCLES while running
//   busy      : high while running
//   done      : one-cycle pulse when a run ends (burst complete or stopped)
//   rise_cnt  : rising edges of sigout since the last accept (wraps)
module freq_synth
  import freq_pkg::*;
#(
  parameter int DIV_W       = 32,
  parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES
) (
  input  logic             clck,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_half,
  input  logic [DIV_W-1:0] cfg_count,
  input  logic             stop,
  output logic             sigout,
  output logic             gate,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] rise_cnt
);

  state_t           r_state;
  state_t           w_nextState;
  logic             r_cfgReady;
  logic             r_busy;
  logic             r_done;
  logic [DIV_W-1:0] r_half;
  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] r_phase;
  logic [DIV_W-1:0] r_periods;
  logic             r_sig;
  logic [DIV_W-1:0] r_rise;

  logic             w_accept;
  logic             w_phaseZero;
  logic             w_burstEnd;
  logic             w_leaveRun;
  logic             w_doneNext;
  logic [DIV_W-1:0] w_heff;

  // Next-state decode. A burst finishes at the end of the low phase that
  // follows the C-th falling edge, i.e. exactly when the wave would rise
  // again; at that point the run ends instead of starting another period.
  // stop and burst completion collapse into the same single exit.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_burstEnd  = 1'b0;
    w_leaveRun  = 1'b0;
    w_doneNext  = 1'b0;
    w_phaseZero = (r_phase == '0);
    w_heff      = (cfg_half == '0) ? DIV_W'(1) : cfg_half;
    case (r_state)
      IDLE: begin
        if (cfg_valid) begin
          w_accept    = 1'b1;
          w_nextState = RUN;
        end
      end
      RUN: begin
        w_burstEnd = w_phaseZero && !r_sig && (r_count != '0) &&
                     (r_periods == r_count);
        if (stop || w_burstEnd) begin
          w_leaveRun  = 1'b1;
          w_doneNext  = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State register plus the handshake/status flags, which are registered
  // copies of where the state is going so every output comes from a flop.
  always_ff @(posedge clck) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cfgReady <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_cfgReady <= (w_nextState == IDLE);
      r_busy     <= (w_nextState == RUN);
      r_done     <= w_doneNext;
    end
  end

  // Wave datapath. The phase counter holds the cycles remaining in the
  // current half-period after this one. The accept itself counts as the
  // first rising edge, since sigout goes high on the following cycle.
  always_ff @(posedge clck) begin
    if (rst) begin
      r_half    <= '0;
      r_count   <= '0;
      r_phase   <= '0;
      r_periods <= '0;
      r_sig     <= 1'b0;
      r_rise    <= '0;
    end else if (w_accept) begin
      r_half    <= w_heff;
      r_count   <= cfg_count;
      r_phase   <= w_heff - DIV_W'(1);
      r_periods <= '0;
      r_sig     <= 1'b1;
      r_rise    <= DIV_W'(1);
    end else if (w_leaveRun) begin
      r_phase   <= '0;
      r_periods <= '0;
      r_sig     <= 1'b0;
    end else if (r_state == RUN) begin
      if (w_phaseZero) begin
        r_phase <= r_half - DIV_W'(1);
        r_sig   <= ~r_sig;
        if (r_sig) begin
          r_periods <= r_periods + DIV_W'(1);
        end else begin
          r_rise <= r_rise + DIV_W'(1);
        end
      end else begin
        r_phase <= r_phase - DIV_W'(1);
      end
    end
  end

  gate_timer #(
    .GATE_CYCLES(GATE_CYCLES)
  ) u_gateTimer (
    .i_clk   (clck),
    .i_rst   (rst),
    .i_clear (w_leaveRun),
    .i_start (w_accept),
    .i_enable(r_state == RUN),
    .o_gate  (gate)
  );

  assign cfg_ready = r_cfgReady;
  assign busy      = r_busy;
  assign done      = r_done;
  assign sigout    = r_sig;
  assign rise_cnt  = r_rise;

endmodule

// File: tb/tb_freq_synth.sv
// Testbench for freq_synth: directed scenarios with literal expectations
// plus a randomized phase, all cross-checked every cycle against a
// behavioural model that derives outputs from the cycle index within a run.
module tb_freq_synth;

  localparam int DIV_W = 8;
  localparam int GATE  = 4;

  logic             clck = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_half = '0;
  logic [DIV_W-1:0] cfg_count = '0;
  logic             stop = 1'b0;
  logic             sigout;
  logic             gate;
  logic             busy;
  logic             done;
  logic [DIV_W-1:0] rise_cnt;

  int nPass = 0;
  int nTotal = 0;
  bit cmpEn = 1'b0;

  // Model state: whether a run is active, the cycle index k within it
  // (k = 1 on the first cycle after accept), and the latched settings.
  bit mRun = 1'b0;
  bit mDone = 1'b0;
  int mK = 0;
  int mH = 1;
  int mC = 0;
  int mRise = 0;

  freq_synth #(
    .DIV_W(DIV_W),
    .GATE_CYCLES(GATE)
  ) dut (
    .clck(clck),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_half(cfg_half),
    .cfg_count(cfg_count),
    .stop(stop),
    .sigout(sigout),
    .gate(gate),
    .busy(busy),
    .done(done),
    .rise_cnt(rise_cnt)
  );

  always #5 clck = ~clck;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input int h, input int c);
    cfg_half  = DIV_W'(h);
    cfg_count = DIV_W'(c);
    cfg_valid = 1'b1;
    @(negedge clck);
    cfg_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clck);
  endtask

  task automatic resetDut();
    stop = 1'b0;
    cfg_valid = 1'b0;
    rst = 1'b1;
    @(negedge clck);
    rst = 1'b0;
    @(negedge clck);
  endtask

  // Behavioural model: outputs follow from k alone; a burst occupies
  // 2*C*H cycles, so the run ends when k would become 2*C*H+1.
  always @(posedge clck) begin
    if (rst) begin
      mRun = 1'b0;
      mDone = 1'b0;
      mRise = 0;
    end else if (mRun) begin
      mDone = 1'b0;
      if (stop) begin
        mRun = 1'b0;
        mDone = 1'b1;
      end else begin
        mK++;
        if (mC != 0 && mK == 2 * mC * mH + 1) begin
          mRun = 1'b0;
          mDone = 1'b1;
        end else begin
          mRise = (mK - 1) / (2 * mH) + 1;
        end
      end
    end else begin
      mDone = 1'b0;
      if (cfg_valid) begin
        mRun = 1'b1;
        mK = 1;
        mH = (cfg_half == 0) ? 1 : int'(cfg_half);
        mC = int'(cfg_count);
        mRise = 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clck) begin
    if (cmpEn) begin
      checkOutput("m_sigout", 32'(sigout),
                  mRun ? 32'(((mK - 1) / mH) % 2 == 0) : 32'd0);
      checkOutput("m_gate", 32'(gate),
                  mRun ? 32'(((mK - 1) / GATE) % 2 == 0) : 32'd0);
      checkOutput("m_busy", 32'(busy), 32'(mRun));
      checkOutput("m_ready", 32'(cfg_ready), 32'(!mRun));
      checkOutput("m_done", 32'(done), 32'(mDone));
      checkOutput("m_rise", 32'(rise_cnt), 32'(mRise % 256));
    end
  end

  initial begin
    logic [11:0] pat;
    logic [15:0] gatePat;
    int cyc;
    int rises;
    int doneCnt;
    logic prevSig;

    // Reset values
    waitCycles(2);
    checkOutput("rst_ready", 32'(cfg_ready), 32'd1);
    checkOutput("rst_sig", 32'(sigout), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rise", 32'(rise_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clck);
    cmpEn = 1'b1;

    // H=3, C=2: wave 111000111000, done at T+13
    applyStimulus(3, 2);
    pat = '0;
    for (int i = 0; i < 12; i++) begin
      pat = {pat[10:0], sigout};
      if (i < 11) @(negedge clck);
    end
    checkOutput("h3_pattern", 32'(pat), 32'b111000111000);
    @(negedge clck);
    checkOutput("h3_done", 32'(done), 32'd1);
    checkOutput("h3_busy", 32'(busy), 32'd0);
    checkOutput("h3_rise", 32'(rise_cnt), 32'd2);
    @(negedge clck);

    // H=0 behaves as H=1, C=4: done at T+9
    applyStimulus(0, 4);
    cyc = 1;
    while (!done && cyc < 50) begin
      @(negedge clck);
      cyc++;
    end
    checkOutput("h0_done_cycle", 32'(cyc), 32'd9);
    checkOutput("h0_rise", 32'(rise_cnt), 32'd4);
    @(negedge clck);

    // H=5, continuous, stop at T+23
    applyStimulus(5, 0);
    waitCycles(22);
    stop = 1'b1;
    @(negedge clck);
    stop = 1'b0;
    checkOutput("stop_sig", 32'(sigout), 32'd0);
    checkOutput("stop_done", 32'(done), 32'd1);
    checkOutput("stop_rise", 32'(rise_cnt), 32'd3);
    @(negedge clck);

    // Gate with GATE=4, H=2
    applyStimulus(2, 0);
    gatePat = '0;
    rises = 0;
    prevSig = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      gatePat = {gatePat[14:0], gate};
      if (sigout && !prevSig) rises++;
      prevSig = sigout;
      if (k < 16) @(negedge clck);
    end
    checkOutput("gate_pattern", 32'(gatePat), 32'b1111000011110000);
    checkOutput("gate_rises", 32'(rises), 32'd4);
    stop = 1'b1;
    @(negedge clck);
    stop = 1'b0;

    // cfg_valid held: back-to-back bursts, H=1, C=1
    resetDut();
    cfg_half = 8'd1;
    cfg_count = 8'd1;
    cfg_valid = 1'b1;
    @(negedge clck);
    checkOutput("b2b_busy1", 32'(busy), 32'd1);
    @(negedge clck);
    checkOutput("b2b_ready2", 32'(cfg_ready), 32'd0);
    @(negedge clck);
    checkOutput("b2b_done3", 32'(done), 32'd1);
    checkOutput("b2b_ready3", 32'(cfg_ready), 32'd1);
    @(negedge clck);
    cfg_valid = 1'b0;
    checkOutput("b2b_busy4", 32'(busy), 32'd1);
    checkOutput("b2b_rise4", 32'(rise_cnt), 32'd1);
    waitCycles(3);

    // Reset mid-run at T+7
    applyStimulus(3, 0);
    waitCycles(6);
    rst = 1'b1;
    @(negedge clck);
    rst = 1'b0;
    checkOutput("mrst_busy", 32'(busy), 32'd0);
    checkOutput("mrst_done", 32'(done), 32'd0);
    checkOutput("mrst_rise", 32'(rise_cnt), 32'd0);
    checkOutput("mrst_gate", 32'(gate), 32'd0);
    @(negedge clck);
    checkOutput("mrst_done2", 32'(done), 32'd0);

    // stop coinciding with burst end: one done pulse
    applyStimulus(2, 1);
    waitCycles(3);
    stop = 1'b1;
    @(negedge clck);
    stop = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) doneCnt++;
      @(negedge clck);
    end
    checkOutput("coincide_done", 32'(doneCnt), 32'd1);

    // rise_cnt wrap: H=1 continuous, 260 rises by T+520
    applyStimulus(1, 0);
    waitCycles(519);
    checkOutput("wrap_rise", 32'(rise_cnt), 32'd4);
    stop = 1'b1;
    @(negedge clck);
    stop = 1'b0;

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      cfg_half  = DIV_W'($urandom_range(0, 5));
      cfg_count = DIV_W'($urandom_range(0, 4));
      cfg_valid = ($urandom_range(0, 2) == 0);
      stop      = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      @(negedge clck);
    end
    cfg_valid = 1'b0;
    stop = 1'b0;
    rst = 1'b0;
    @(negedge clck);
    cmpEn = 1'b0;

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
